// File: rtl/hpu_pkg.sv
// Shared types for the HPU physical-register mark (ready scoreboard).
// Speculative load wakeup is compiled in with HPU_PRM_SPEC_WAKE_EN.
package hpu_pkg;

  localparam int unsigned PRM_PHY_REGS = 64;
  localparam int unsigned PRM_PHY_W    = $clog2(PRM_PHY_REGS);
  localparam int unsigned PRM_CNT_W    = PRM_PHY_W + 1;
  localparam int unsigned PRM_CKPT_W   = 4;

  typedef enum logic [1:0] {
    READY = 2'd0,
    FLY   = 2'd1,
    SPEC  = 2'd2
  } sr_status_e;

  typedef logic [PRM_CKPT_W-1:0] ckpt_t;

  typedef struct packed {
    logic                 en;
    logic [PRM_PHY_W-1:0] rdst_index;
  } awake_index_t;

  typedef struct packed {
    logic  en;
    ckpt_t ckpt;
  } update_ckpt_t;

  // True when tag lies in the circular interval (rcov, pref].
  function automatic logic chk_ckpt(input ckpt_t tag, input ckpt_t rcov, input ckpt_t pref);
    ckpt_t d_tag;
    ckpt_t d_pref;
    d_tag  = tag - rcov;
    d_pref = pref - rcov;
    return (d_tag != '0) && (d_tag <= d_pref);
  endfunction

endpackage

// File: rtl/hpu_prm_spec_pipe.sv
// Fixed-latency shift of speculative wakes awaiting confirm/cancel.
// Only instantiated when HPU_PRM_SPEC_WAKE_EN is defined.
module hpu_prm_spec_pipe
  import hpu_pkg::*;
#(
  parameter int unsigned SPEC_LAT = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  awake_index_t            push_i,
  input  logic [PRM_PHY_REGS-1:0] kill_i,
  input  logic                    flush_i,
  output awake_index_t            head_o
);

  awake_index_t stage_q [SPEC_LAT];
  awake_index_t stage_d [SPEC_LAT];

  // Shift one stage per cycle; an entry dies if its register was touched non-speculatively.
  always_comb begin
    stage_d[0] = push_i;
    for (int unsigned k = 1; k < SPEC_LAT; k++) begin
      stage_d[k] = stage_q[k-1];
    end
    for (int unsigned k = 0; k < SPEC_LAT; k++) begin
      if (flush_i || kill_i[stage_d[k].rdst_index]) begin
        stage_d[k].en = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned k = 0; k < SPEC_LAT; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < SPEC_LAT; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign head_o = stage_q[SPEC_LAT-1];

endmodule

// File: rtl/hpu_prm_spec.sv
// Physical-register READY/FLY/SPEC scoreboard with same-cycle query bypass.
// Define HPU_PRM_SPEC_WAKE_EN to enable speculative load wakeup.
module hpu_prm_spec
  import hpu_pkg::*;
#(
  parameter int unsigned DEC_LANES    = 2,
  parameter int unsigned SRC_PER_LANE = 2,
  parameter int unsigned WAKE_PORTS   = 4,
  parameter int unsigned SPEC_LAT     = 3
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_i,
  input  logic                                                   ctrl__inst_flush_en_i,
  input  update_ckpt_t                                           id__ckpt_rcov_i,
  input  ckpt_t                                                  id__prefet_ckpt_i,
  input  logic [DEC_LANES-1:0]                                   id_prm__rdst_en_i,
  input  logic [DEC_LANES-1:0][PRM_PHY_W-1:0]                    id_prm__phy_rdst_index_i,
  input  ckpt_t [DEC_LANES-1:0]                                  id_prm__ckpt_i,
  input  logic [DEC_LANES-1:0][SRC_PER_LANE-1:0][PRM_PHY_W-1:0]  id_prm__phy_rs_index_i,
  output sr_status_e [DEC_LANES-1:0][SRC_PER_LANE-1:0]           prm_id__phy_rs_ready_o,
  input  awake_index_t [WAKE_PORTS-1:0]                          wb_prm__update_prm_i,
  input  awake_index_t                                           lsu_prm__spec_wake_i,
  input  logic                                                   lsu_prm__spec_cancel_i,
  output logic [PRM_CNT_W-1:0]                                   prm_id__fly_cnt_o
);

  logic                    flush_q, flush_d;
  update_ckpt_t            rcov_q, rcov_d;
  ckpt_t                   pref_q, pref_d;
  sr_status_e              status_q [PRM_PHY_REGS];
  sr_status_e              status_d [PRM_PHY_REGS];
  ckpt_t                   tag_q    [PRM_PHY_REGS];
  ckpt_t                   tag_d    [PRM_PHY_REGS];
  logic [PRM_CNT_W-1:0]    fly_cnt_q, fly_cnt_d;
  logic [PRM_CNT_W-1:0]    fly_inc, fly_dec;
  logic [PRM_PHY_REGS-1:0] rcov_hit_c;

  // Flush and recovery are retimed one stage; pref travels with the recovery request.
  always_comb begin
    flush_d = ctrl__inst_flush_en_i;
    rcov_d  = id__ckpt_rcov_i;
    pref_d  = id__prefet_ckpt_i;
  end

  always_comb begin
    rcov_hit_c = '0;
    for (int unsigned r = 1; r < PRM_PHY_REGS; r++) begin
      rcov_hit_c[r] = rcov_q.en && chk_ckpt(tag_q[r], rcov_q.ckpt, pref_q);
    end
  end

`ifdef HPU_PRM_SPEC_WAKE_EN
  awake_index_t            spec_push_c;
  awake_index_t            head_c;
  logic                    head_live_c;
  logic [PRM_PHY_REGS-1:0] kill_c;

  // Only a FLY, nonzero register can enter the speculative window.
  always_comb begin
    spec_push_c    = lsu_prm__spec_wake_i;
    spec_push_c.en = lsu_prm__spec_wake_i.en
                     && (lsu_prm__spec_wake_i.rdst_index != '0)
                     && (status_q[lsu_prm__spec_wake_i.rdst_index] == FLY);
  end

  always_comb begin
    kill_c = rcov_hit_c;
    for (int unsigned l = 0; l < DEC_LANES; l++) begin
      if (id_prm__rdst_en_i[l]) kill_c[id_prm__phy_rdst_index_i[l]] = 1'b1;
    end
    for (int unsigned w = 0; w < WAKE_PORTS; w++) begin
      if (wb_prm__update_prm_i[w].en) kill_c[wb_prm__update_prm_i[w].rdst_index] = 1'b1;
    end
  end

  hpu_prm_spec_pipe #(
    .SPEC_LAT (SPEC_LAT)
  ) u_spec_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (spec_push_c),
    .kill_i  (kill_c),
    .flush_i (flush_q),
    .head_o  (head_c)
  );

  assign head_live_c = head_c.en && (status_q[head_c.rdst_index] == SPEC);
`else
  logic unused_spec;
  assign unused_spec = ^{lsu_prm__spec_wake_i, lsu_prm__spec_cancel_i};
`endif

  // Per-register next state, lowest priority first; counter tracks every READY edge.
  always_comb begin
    fly_inc = '0;
    fly_dec = '0;
    for (int unsigned r = 0; r < PRM_PHY_REGS; r++) begin
      status_d[r] = status_q[r];
      tag_d[r]    = tag_q[r];
    end
    status_d[0] = READY;
    tag_d[0]    = '0;
    for (int unsigned r = 1; r < PRM_PHY_REGS; r++) begin
      for (int unsigned l = 0; l < DEC_LANES; l++) begin
        if (id_prm__rdst_en_i[l] && (id_prm__phy_rdst_index_i[l] == PRM_PHY_W'(r))) begin
          status_d[r] = FLY;
          tag_d[r]    = id_prm__ckpt_i[l];
        end
      end
`ifdef HPU_PRM_SPEC_WAKE_EN
      if (spec_push_c.en && (spec_push_c.rdst_index == PRM_PHY_W'(r))) begin
        status_d[r] = SPEC;
      end
`endif
      for (int unsigned w = 0; w < WAKE_PORTS; w++) begin
        if (wb_prm__update_prm_i[w].en && (wb_prm__update_prm_i[w].rdst_index == PRM_PHY_W'(r))) begin
          status_d[r] = READY;
        end
      end
`ifdef HPU_PRM_SPEC_WAKE_EN
      if (head_live_c && (head_c.rdst_index == PRM_PHY_W'(r))) begin
        status_d[r] = lsu_prm__spec_cancel_i ? FLY : READY;
      end
`endif
      if (rcov_hit_c[r]) status_d[r] = READY;
      if (flush_q)       status_d[r] = READY;
      if ((status_q[r] == READY) && (status_d[r] != READY)) begin
        fly_inc = fly_inc + PRM_CNT_W'(1);
      end else if ((status_q[r] != READY) && (status_d[r] == READY)) begin
        fly_dec = fly_dec + PRM_CNT_W'(1);
      end
    end
    fly_cnt_d = fly_cnt_q + fly_inc - fly_dec;
  end

  // Source query with same-cycle bypass; later rules override earlier ones.
  always_comb begin
    logic [PRM_PHY_W-1:0] q_idx;
    sr_status_e           q_st;
    for (int unsigned i = 0; i < DEC_LANES; i++) begin
      for (int unsigned s = 0; s < SRC_PER_LANE; s++) begin
        q_idx = id_prm__phy_rs_index_i[i][s];
        q_st  = status_q[q_idx];
        for (int unsigned w = 0; w < WAKE_PORTS; w++) begin
          if (wb_prm__update_prm_i[w].en && (wb_prm__update_prm_i[w].rdst_index == q_idx)) begin
            q_st = READY;
          end
        end
`ifdef HPU_PRM_SPEC_WAKE_EN
        if (spec_push_c.en && (spec_push_c.rdst_index == q_idx)) q_st = SPEC;
        if (head_live_c && lsu_prm__spec_cancel_i && (head_c.rdst_index == q_idx)) q_st = FLY;
`endif
        for (int unsigned j = 0; j < i; j++) begin
          if (id_prm__rdst_en_i[j] && (id_prm__phy_rdst_index_i[j] == q_idx)) q_st = FLY;
        end
        if (q_idx == '0) q_st = READY;
        prm_id__phy_rs_ready_o[i][s] = q_st;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      flush_q   <= 1'b0;
      rcov_q    <= '0;
      pref_q    <= '0;
      fly_cnt_q <= '0;
      for (int unsigned r = 0; r < PRM_PHY_REGS; r++) begin
        status_q[r] <= READY;
        tag_q[r]    <= '0;
      end
    end else begin
      flush_q   <= flush_d;
      rcov_q    <= rcov_d;
      pref_q    <= pref_d;
      fly_cnt_q <= fly_cnt_d;
      for (int unsigned r = 0; r < PRM_PHY_REGS; r++) begin
        status_q[r] <= status_d[r];
        tag_q[r]    <= tag_d[r];
      end
    end
  end

  assign prm_id__fly_cnt_o = fly_cnt_q;

endmodule
